// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and default busy durations.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Operand/request/result bundle between the pipeline and the multiply/divide unit.
interface mdu_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic [2:0]  op;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output a, b, start, op, input busy, hi, lo);
  modport slave  (input a, b, start, op, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: result computed at request time, held pending, and
// committed to HI/LO after a fixed number of busy cycles.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | accepting requests; MTHI/MTLO write immediately
//   ST_BUSY | counting down; pending result commits when counter reaches 1
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES)) + 1;

  state_e           state;
  logic             busy_q;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      pending;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_s;
  logic [31:0] div_u;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [63:0] result;

  always_comb begin
    prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    prod_u = {32'd0, bus.a} * {32'd0, bus.b};
    // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow corner
    a_mag  = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    b_mag  = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
    div_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    div_u  = (bus.b == 32'd0) ? 32'd1 : bus.b;
    q_mag  = a_mag / div_s;
    r_mag  = a_mag % div_s;
    q_s    = (bus.a[31] ^ bus.b[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = bus.a[31] ? (~r_mag + 32'd1) : r_mag;
    result = '0;
    case (bus.op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = (bus.b == 32'd0) ? {hi_q, lo_q} : {r_s, q_s};
      OP_DIVU:  result = (bus.b == 32'd0) ? {hi_q, lo_q} : {bus.a % div_u, bus.a / div_u};
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt     <= '0;
      pending <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                pending <= result;
                cnt     <= CNT_W'(MULT_CYCLES);
                state   <= ST_BUSY;
                busy_q  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                pending <= result;
                cnt     <= CNT_W'(DIV_CYCLES);
                state   <= ST_BUSY;
                busy_q  <= 1'b1;
              end
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi_q   <= pending[63:32];
            lo_q   <= pending[31:0];
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written busy/reset corner sequences.
module tb_mdu;
  import mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nhi, output logic [31:0] nlo, output int n);
    longint          sa, sb, p, q, r;
    longint unsigned pu;
    nhi = exp_hi; nlo = exp_lo; n = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: begin p = sa * sb; nhi = p[63:32]; nlo = p[31:0]; n = NM; end
      3'b001: begin pu = {32'd0, a} * {32'd0, b}; nhi = pu[63:32]; nlo = pu[31:0]; n = NM; end
      3'b010: begin
        n = ND;
        if (b != 0) begin q = sa / sb; r = sa % sb; nhi = r[31:0]; nlo = q[31:0]; end
      end
      3'b011: begin
        n = ND;
        if (b != 0) begin nhi = a % b; nlo = a / b; end
      end
      3'b100: nhi = a;
      3'b101: nlo = a;
      default: ;
    endcase
  endtask

  // Called at a negedge. Issues one request, optionally injects a second start
  // during busy cycle inj_cyc, and returns the number of busy cycles seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input logic [2:0] inj_op, input logic [31:0] inj_a,
                        output int cycles, output int early);
    logic [31:0] h0, l0;
    h0 = exp_hi; l0 = exp_lo;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom);
    cycles = 0; early = 0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (bus.hi !== h0 || bus.lo !== l0) early++;
      if (cycles == inj_cyc) begin
        bus.start = 1'b1; bus.op = inj_op; bus.a = inj_a; bus.b = $urandom;
      end else begin
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic do_check(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj_cyc, input logic [2:0] inj_op);
    logic [31:0] nhi, nlo;
    int n, cyc, early;
    model(op, a, b, nhi, nlo, n);
    run_op(op, a, b, inj_cyc, inj_op, 32'h5, cyc, early);
    chk({name, " busy_cycles"}, 64'(cyc), 64'(n));
    chk({name, " early_commit"}, 64'(early), 64'd0);
    chk({name, " hi_lo"}, {bus.hi, bus.lo}, {nhi, nlo});
    exp_hi = nhi; exp_lo = nlo;
  endtask

  vec_t vecs[8];

  initial begin
    int bad;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, NM};
    vecs[1] = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, NM};
    vecs[2] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, ND};
    vecs[3] = '{3'b100, 32'h11111111, 32'h0,        32'h11111111, 32'hFFFFFFFD, 0};
    vecs[4] = '{3'b101, 32'h22222222, 32'h0,        32'h11111111, 32'h22222222, 0};
    vecs[5] = '{3'b010, 32'h00000005, 32'h0,        32'h11111111, 32'h22222222, ND};
    vecs[6] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, ND};
    vecs[7] = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, ND};

    reset = 1'b0; bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    #1;
    chk("reset busy_hi_lo", {31'd0, bus.busy, bus.hi, bus.lo}, 95'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // First request issued so that it lands on the first edge after release
    foreach (vecs[i]) begin
      int cyc, early;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 3'b000, 32'h0, cyc, early);
      chk($sformatf("vec%0d busy_cycles", i), 64'(cyc), 64'(vecs[i].cycles));
      chk($sformatf("vec%0d early_commit", i), 64'(early), 64'd0);
      chk($sformatf("vec%0d hi_lo", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
      exp_hi = vecs[i].hi; exp_lo = vecs[i].lo;
    end

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      do_check($sformatf("rand%0d", i), rop, ra, rb, 0, 3'b000);
    end

    // Starts during busy (cycle 2 and the commit cycle) are dropped
    do_check("mtlo_in_busy", 3'b010, 32'd100, 32'd7, 2, 3'b101);
    do_check("mthi_at_commit", 3'b000, 32'h12345678, 32'h9ABCDEF0, NM, 3'b100);

    // Reserved op
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    chk("reserved_op", {31'd0, bus.busy, bus.hi, bus.lo}, {31'd0, 1'b0, exp_hi, exp_lo});

    // Reset in busy cycle 4 aborts the divide
    bus.start = 1'b1; bus.op = 3'b011; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 4; c++) @(negedge clk);
    chk("pre_reset busy", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("async_reset busy_hi_lo", {31'd0, bus.busy, bus.hi, bus.lo}, 95'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    bad = 0;
    for (int c = 0; c < ND + 3; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) bad++;
    end
    chk("no_commit_after_reset", 64'(bad), 64'd0);

    // Request issued together with reset release is accepted
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_check("first_after_reset", 3'b001, 32'd3, 32'd4, 0, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy duration of MULT/MULTU in cycles (>=1).
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU in cycles (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port a  input  32  operand rs, driven by the forwarding-mux output.
REQ-006 SHALL have port b  input  32  operand rt, driven by the forwarding-mux output.
REQ-007 SHALL have port start  input  1  one-cycle request; op, a and b are valid with it.
REQ-008 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
REQ-009 SHALL have port busy  output  1  high while a multiply/divide is in flight.
REQ-010 SHALL have port hi  output  32  committed HI register.
REQ-011 SHALL have port lo  output  32  committed LO register.

Function
REQ-012 SHALL implement two states: IDLE and BUSY; busy = (state == BUSY), registered.
REQ-013 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL sample a, b and op at that edge, compute the 64-bit result, hold it in a pending register, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-014 Later changes on a, b or op SHALL NOT affect an operation already accepted.
REQ-015 In BUSY, the counter SHALL decrement each edge; on the edge where it equals 1, HI/LO SHALL take the pending result and the state SHALL return to IDLE.
REQ-016 busy SHALL therefore be high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), and the new hi/lo SHALL be visible in the first cycle busy is low.
REQ-017 hi/lo SHALL always show committed values; the pending result SHALL never appear on them early.
REQ-018 MULT/MULTU SHALL produce a 64-bit signed/unsigned product: HI = bits 63:32, LO = bits 31:0.
REQ-019 DIV/DIVU SHALL produce LO = quotient and HI = remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-020 Divide by zero (b = 0) SHALL still occupy BUSY for DIV_CYCLES, and HI and LO SHALL stay unchanged at commit.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO = 0x80000000 and HI = 0.
REQ-022 MTHI/MTLO in IDLE SHALL write a into HI/LO at the start edge, with no busy cycle; the other register stays unchanged.
REQ-023 Any start while BUSY, including the commit cycle, SHALL be ignored with no effect on state, pending result or HI/LO.
REQ-024 start with a reserved op SHALL be ignored.

Reset
REQ-025 While reset = 0, state SHALL be IDLE, busy = 0, counter = 0, HI = 0, LO = 0 and pending = 0, taking effect immediately without a clock edge.
REQ-026 A reset during BUSY SHALL abort the operation and discard the pending result.
REQ-027 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-028 A shared package SHALL hold: the op encodings, the state encoding, and the MULT_CYCLES/DIV_CYCLES defaults.
REQ-029 The block SHALL be a single module with inline combinational multiply/divide and no sub-module; the counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.

Verification
REQ-030 Signed multiply: MULT a=0xFFFFFFFE, b=0x00000003 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 Unsigned multiply: MULTU a=0xFFFFFFFE, b=0x00000003 -> after 5 busy cycles HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 Signed divide: DIV a=0xFFFFFFF9, b=0x00000002 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 Divide by zero:
- MTHI a=0x11111111, then MTLO a=0x22222222, then DIV a=5, b=0
- required: busy 10 cycles, then HI=0x11111111, LO=0x22222222.
REQ-034 Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
REQ-035 Ignored start and reset mid-operation:
- MTLO a=0x5 issued during DIV busy cycle 2 -> LO unchanged.
- reset low in busy cycle 4 -> busy=0, HI=LO=0 at once, and no commit after reset releases.
